// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control path: state codes, opcodes and ALUOp values.
// The ALU control decoder imports the same ALUOp constants.
package mips_ctrl_pkg;

  localparam logic [3:0] FETCH         = 4'd0;
  localparam logic [3:0] DECODE        = 4'd1;
  localparam logic [3:0] MEM_ADDR      = 4'd2;
  localparam logic [3:0] MEM_READ      = 4'd3;
  localparam logic [3:0] MEM_WB        = 4'd4;
  localparam logic [3:0] MEM_WRITE     = 4'd5;
  localparam logic [3:0] EXECUTE       = 4'd6;
  localparam logic [3:0] R_COMPLETE    = 4'd7;
  localparam logic [3:0] BRANCH        = 4'd8;
  localparam logic [3:0] JUMP          = 4'd9;
  localparam logic [3:0] ADDI_EXEC     = 4'd10;
  localparam logic [3:0] ADDI_COMPLETE = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_supported_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/control_output_decoder.sv
// Pure state-to-control-bundle decode for the multi-cycle MIPS FSM.
// Anything not set for a state stays 0; unused state codes decode to all zeros.
module control_output_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source
);

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALUOP_ADD;
    pc_source     = PCSRC_ALU;
    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = SRCB_FOUR;
      end
      // Branch target is computed speculatively while the opcode is decoded.
      DECODE: alu_src_b = SRCB_IMM_SH;
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      R_COMPLETE: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ADDI_COMPLETE: reg_write = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS datapath: state register and next-state logic.
// Outputs are a Moore decode of the state, except illegal_op which also looks at the opcode.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state
);

  logic [3:0] r_state;
  logic [3:0] w_next_state;

  always_comb begin
    w_next_state = FETCH;
    case (r_state)
      FETCH: w_next_state = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next_state = MEM_ADDR;
          OP_RTYPE:     w_next_state = EXECUTE;
          OP_BEQ:       w_next_state = BRANCH;
          OP_J:         w_next_state = JUMP;
          OP_ADDI:      w_next_state = ADDI_EXEC;
          default:      w_next_state = FETCH;
        endcase
      end
      // IR is stable here, so the opcode is re-read to split lw from sw.
      MEM_ADDR: begin
        if (opcode == OP_LW)
          w_next_state = MEM_READ;
        else if (opcode == OP_SW)
          w_next_state = MEM_WRITE;
        else
          w_next_state = FETCH;
      end
      MEM_READ:  w_next_state = MEM_WB;
      EXECUTE:   w_next_state = R_COMPLETE;
      ADDI_EXEC: w_next_state = ADDI_COMPLETE;
      default:   w_next_state = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= FETCH;
    else
      r_state <= w_next_state;
  end

  assign state      = r_state;
  assign illegal_op = (r_state == DECODE) && !is_supported_op(opcode);

  control_output_decoder u_decode (
    .state         (r_state),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through its state
// sequence, sampling on the falling edge, plus reset and illegal-opcode scenarios.
module tb_multicycle_control;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  int n_checks;
  int n_fail;

  multicycle_control dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .illegal_op    (illegal_op),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    n_checks += 8;
    if (state !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
    if (mem_read !== 1'b1) begin n_fail++; $display("FAIL reset_mem_read: got %b want 1", mem_read); end
    if (pc_write !== 1'b1) begin n_fail++; $display("FAIL reset_pc_write: got %b want 1", pc_write); end
    if (ir_write !== 1'b1) begin n_fail++; $display("FAIL reset_ir_write: got %b want 1", ir_write); end
    if (alu_src_b !== 2'b01) begin n_fail++; $display("FAIL reset_alu_src_b: got %b want 01", alu_src_b); end
    if (reg_write !== 1'b0) begin n_fail++; $display("FAIL reset_reg_write: got %b want 0", reg_write); end
    if (mem_write !== 1'b0) begin n_fail++; $display("FAIL reset_mem_write: got %b want 0", mem_write); end
    if (illegal_op !== 1'b0) begin n_fail++; $display("FAIL reset_illegal_op: got %b want 0", illegal_op); end
    $display("reset: state=%0d mem_read=%b pc_write=%b alu_src_b=%b", state, mem_read, pc_write, alu_src_b);
    // Hold reset across a rising edge, then release on a falling edge.
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (state !== 4'd0) begin n_fail++; $display("FAIL reset_hold_state: got %0d want 0", state); end
    rst = 1'b0;
  endtask

  task automatic test_lw();
    logic [3:0] seq [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    logic       wb  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       iod [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    opcode = 6'b100011;
    for (int i = 0; i < 6; i++) begin
      if (i != 0) @(negedge clk);
      n_checks += 5;
      if (state !== seq[i]) begin n_fail++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, seq[i]); end
      if (reg_write !== wb[i]) begin n_fail++; $display("FAIL lw_reg_write[%0d]: got %b want %b", i, reg_write, wb[i]); end
      if (mem_to_reg !== wb[i]) begin n_fail++; $display("FAIL lw_mem_to_reg[%0d]: got %b want %b", i, mem_to_reg, wb[i]); end
      if (i_or_d !== iod[i]) begin n_fail++; $display("FAIL lw_i_or_d[%0d]: got %b want %b", i, i_or_d, iod[i]); end
      if (illegal_op !== 1'b0) begin n_fail++; $display("FAIL lw_illegal_op[%0d]: got %b want 0", i, illegal_op); end
      $display("lw step %0d: state=%0d reg_write=%b mem_to_reg=%b", i, state, reg_write, mem_to_reg);
    end
  endtask

  task automatic test_rtype();
    logic [3:0] seq  [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    logic [1:0] aop  [5] = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
    logic       done [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    opcode = 6'b000000;
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      n_checks += 4;
      if (state !== seq[i]) begin n_fail++; $display("FAIL rtype_state[%0d]: got %0d want %0d", i, state, seq[i]); end
      if (alu_op !== aop[i]) begin n_fail++; $display("FAIL rtype_alu_op[%0d]: got %b want %b", i, alu_op, aop[i]); end
      if (reg_dst !== done[i]) begin n_fail++; $display("FAIL rtype_reg_dst[%0d]: got %b want %b", i, reg_dst, done[i]); end
      if (reg_write !== done[i]) begin n_fail++; $display("FAIL rtype_reg_write[%0d]: got %b want %b", i, reg_write, done[i]); end
      $display("rtype step %0d: state=%0d alu_op=%b reg_dst=%b reg_write=%b", i, state, alu_op, reg_dst, reg_write);
    end
  endtask

  task automatic test_sw_beq_j();
    logic [3:0] sw_seq  [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    logic       sw_mw   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] beq_seq [4] = '{4'd0, 4'd1, 4'd8, 4'd0};
    logic [1:0] beq_aop [4] = '{2'b00, 2'b00, 2'b01, 2'b00};
    logic       beq_pwc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] j_seq   [4] = '{4'd0, 4'd1, 4'd9, 4'd0};
    logic [1:0] j_psrc  [4] = '{2'b00, 2'b00, 2'b10, 2'b00};
    logic       j_pw    [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    opcode = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      n_checks += 3;
      if (state !== sw_seq[i]) begin n_fail++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, state, sw_seq[i]); end
      if (mem_write !== sw_mw[i]) begin n_fail++; $display("FAIL sw_mem_write[%0d]: got %b want %b", i, mem_write, sw_mw[i]); end
      if (reg_write !== 1'b0) begin n_fail++; $display("FAIL sw_reg_write[%0d]: got %b want 0", i, reg_write); end
      $display("sw step %0d: state=%0d mem_write=%b", i, state, mem_write);
    end
    opcode = 6'b000100;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      n_checks += 4;
      if (state !== beq_seq[i]) begin n_fail++; $display("FAIL beq_state[%0d]: got %0d want %0d", i, state, beq_seq[i]); end
      if (alu_op !== beq_aop[i]) begin n_fail++; $display("FAIL beq_alu_op[%0d]: got %b want %b", i, alu_op, beq_aop[i]); end
      if (pc_write_cond !== beq_pwc[i]) begin n_fail++; $display("FAIL beq_pc_write_cond[%0d]: got %b want %b", i, pc_write_cond, beq_pwc[i]); end
      if (pc_source !== {1'b0, beq_pwc[i]}) begin n_fail++; $display("FAIL beq_pc_source[%0d]: got %b want %b", i, pc_source, {1'b0, beq_pwc[i]}); end
      $display("beq step %0d: state=%0d alu_op=%b pc_write_cond=%b", i, state, alu_op, pc_write_cond);
    end
    opcode = 6'b000010;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      n_checks += 3;
      if (state !== j_seq[i]) begin n_fail++; $display("FAIL j_state[%0d]: got %0d want %0d", i, state, j_seq[i]); end
      if (pc_source !== j_psrc[i]) begin n_fail++; $display("FAIL j_pc_source[%0d]: got %b want %b", i, pc_source, j_psrc[i]); end
      if (pc_write !== j_pw[i]) begin n_fail++; $display("FAIL j_pc_write[%0d]: got %b want %b", i, pc_write, j_pw[i]); end
      $display("j step %0d: state=%0d pc_source=%b pc_write=%b", i, state, pc_source, pc_write);
    end
  endtask

  task automatic test_illegal();
    logic [3:0] seq [3] = '{4'd0, 4'd1, 4'd0};
    logic       ill [3] = '{1'b0, 1'b1, 1'b0};
    opcode = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clk);
      n_checks += 4;
      if (state !== seq[i]) begin n_fail++; $display("FAIL illegal_state[%0d]: got %0d want %0d", i, state, seq[i]); end
      if (illegal_op !== ill[i]) begin n_fail++; $display("FAIL illegal_flag[%0d]: got %b want %b", i, illegal_op, ill[i]); end
      if (reg_write !== 1'b0) begin n_fail++; $display("FAIL illegal_reg_write[%0d]: got %b want 0", i, reg_write); end
      if (mem_write !== 1'b0) begin n_fail++; $display("FAIL illegal_mem_write[%0d]: got %b want 0", i, mem_write); end
      $display("illegal step %0d: state=%0d illegal_op=%b", i, state, illegal_op);
    end
  endtask

  task automatic test_reset_mid_lw();
    opcode = 6'b100011;
    repeat (3) @(negedge clk);
    n_checks++;
    if (state !== 4'd3) begin n_fail++; $display("FAIL midrst_pre_state: got %0d want 3", state); end
    #1 rst = 1'b1;
    #1;
    n_checks += 3;
    if (state !== 4'd0) begin n_fail++; $display("FAIL midrst_async_state: got %0d want 0", state); end
    if (reg_write !== 1'b0) begin n_fail++; $display("FAIL midrst_reg_write: got %b want 0", reg_write); end
    if (mem_read !== 1'b1) begin n_fail++; $display("FAIL midrst_mem_read: got %b want 1", mem_read); end
    $display("midrst: state=%0d reg_write=%b", state, reg_write);
    // Reset spans a rising edge that would otherwise have entered MEM_WB.
    @(negedge clk);
    n_checks += 2;
    if (state !== 4'd0) begin n_fail++; $display("FAIL midrst_held_state: got %0d want 0", state); end
    if (reg_write !== 1'b0) begin n_fail++; $display("FAIL midrst_held_reg_write: got %b want 0", reg_write); end
    rst = 1'b0;
  endtask

  task automatic test_addi();
    logic [3:0] seq  [5] = '{4'd0, 4'd1, 4'd10, 4'd11, 4'd0};
    logic [1:0] srcb [5] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
    logic       rw   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       sa   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    opcode = 6'b001000;
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      n_checks += 5;
      if (state !== seq[i]) begin n_fail++; $display("FAIL addi_state[%0d]: got %0d want %0d", i, state, seq[i]); end
      if (alu_src_b !== srcb[i]) begin n_fail++; $display("FAIL addi_alu_src_b[%0d]: got %b want %b", i, alu_src_b, srcb[i]); end
      if (reg_write !== rw[i]) begin n_fail++; $display("FAIL addi_reg_write[%0d]: got %b want %b", i, reg_write, rw[i]); end
      if (alu_src_a !== sa[i]) begin n_fail++; $display("FAIL addi_alu_src_a[%0d]: got %b want %b", i, alu_src_a, sa[i]); end
      if (reg_dst !== 1'b0) begin n_fail++; $display("FAIL addi_reg_dst[%0d]: got %b want 0", i, reg_dst); end
      $display("addi step %0d: state=%0d alu_src_b=%b reg_write=%b", i, state, alu_src_b, reg_write);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    opcode   = 6'b000000;
    test_reset();
    test_lw();
    test_rtype();
    test_sw_beq_j();
    test_illegal();
    test_reset_mid_lw();
    test_addi();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
